// File: rtl/dcache_pkg.sv
// Shared dcache definitions: line geometry and the writeback FSM state encoding.
// Also imported by the miss/refill controller.
package dcache_pkg;

  localparam int NUM_BANKS  = 8;
  localparam int BEAT_IDX_W = 3;
  localparam int LINE_OFF_W = 6;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    SEND,
    WAIT_ACK
  } wb_state_e;

endpackage

// File: rtl/dcache_writeback_unit.sv
// Victim-line writeback: one wide read of the chosen way, then an 8-beat
// valid/ready burst to memory, then wait for the write ack and pulse done.
module dcache_writeback_unit
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 9,
  parameter int PADDR_WIDTH = 32
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic                                 wb_req_valid,
  output logic                                 wb_req_ready,
  input  logic [ADDR_WIDTH-1:0]                wb_req_set,
  input  logic                                 wb_req_way,
  input  logic [PADDR_WIDTH-1:0]               wb_req_paddr,
  output logic [NUM_BANKS-1:0]                 ce_way0,
  output logic [NUM_BANKS-1:0]                 ce_way1,
  output logic [ADDR_WIDTH-1:0]                readwayaddr_way0,
  output logic [ADDR_WIDTH-1:0]                readwayaddr_way1,
  input  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] dout_way0,
  input  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] dout_way1,
  output logic                                 mem_wr_valid,
  input  logic                                 mem_wr_ready,
  output logic [PADDR_WIDTH-1:0]               mem_wr_addr,
  output logic [DATA_WIDTH-1:0]                mem_wr_data,
  output logic [BEAT_IDX_W-1:0]                mem_wr_beat,
  output logic                                 mem_wr_last,
  input  logic                                 mem_wr_ack,
  output logic                                 wb_done,
  output logic                                 wb_busy
);

  localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(NUM_BANKS - 1);

  wb_state_e                             state_q, state_d;
  logic [ADDR_WIDTH-1:0]                 set_q, set_d;
  logic                                  way_q, way_d;
  logic [PADDR_WIDTH-1:0]                addr_q, addr_d;
  logic [BEAT_IDX_W-1:0]                 beat_q, beat_d;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]  line_q, line_d;
  logic                                  done_q, done_d;

  // Offset bits of the victim address never reach memory; the burst is line aligned.
  logic unused_paddr_off;
  assign unused_paddr_off = ^wb_req_paddr[LINE_OFF_W-1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      set_q   <= '0;
      way_q   <= 1'b0;
      addr_q  <= '0;
      beat_q  <= '0;
      line_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      way_q   <= way_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    way_d   = way_q;
    addr_d  = addr_q;
    beat_d  = beat_q;
    line_d  = line_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (wb_req_valid) begin
          set_d   = wb_req_set;
          way_d   = wb_req_way;
          addr_d  = {wb_req_paddr[PADDR_WIDTH-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
          state_d = READ;
        end
      end
      READ: state_d = CAPTURE;
      CAPTURE: begin
        // Array data is valid the cycle after the bank enables.
        line_d  = way_q ? dout_way1 : dout_way0;
        beat_d  = '0;
        state_d = SEND;
      end
      SEND: begin
        if (mem_wr_ready) begin
          if (beat_q == LAST_BEAT) begin
            state_d = WAIT_ACK;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      WAIT_ACK: begin
        if (mem_wr_ack) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ce_way0          = '0;
    ce_way1          = '0;
    readwayaddr_way0 = '0;
    readwayaddr_way1 = '0;
    if (state_q == READ) begin
      if (way_q) begin
        ce_way1          = '1;
        readwayaddr_way1 = set_q;
      end else begin
        ce_way0          = '1;
        readwayaddr_way0 = set_q;
      end
    end
  end

  assign wb_req_ready = (state_q == IDLE);
  assign wb_busy      = (state_q != IDLE);
  assign mem_wr_valid = (state_q == SEND);
  assign mem_wr_last  = (state_q == SEND) && (beat_q == LAST_BEAT);
  assign mem_wr_addr  = addr_q;
  assign mem_wr_data  = line_q[beat_q];
  assign mem_wr_beat  = beat_q;
  assign wb_done      = done_q;

endmodule

// File: tb/tb_dcache_writeback_unit.sv
// Scoreboard bench for dcache_writeback_unit: directed requests push expected
// beats; a negedge monitor pops and compares every accepted memory beat.
module tb_dcache_writeback_unit;

  localparam int DW = 64;
  localparam int AW = 9;
  localparam int PW = 32;

  logic                 clock;
  logic                 reset_n;
  logic                 wb_req_valid;
  logic                 wb_req_ready;
  logic [AW-1:0]        wb_req_set;
  logic                 wb_req_way;
  logic [PW-1:0]        wb_req_paddr;
  logic [7:0]           ce_way0, ce_way1;
  logic [AW-1:0]        readwayaddr_way0, readwayaddr_way1;
  logic [7:0][DW-1:0]   dout_way0 = '0;
  logic [7:0][DW-1:0]   dout_way1 = '0;
  logic                 mem_wr_valid;
  logic                 mem_wr_ready = 1'b1;
  logic [PW-1:0]        mem_wr_addr;
  logic [DW-1:0]        mem_wr_data;
  logic [2:0]           mem_wr_beat;
  logic                 mem_wr_last;
  logic                 mem_wr_ack;
  logic                 wb_done;
  logic                 wb_busy;

  int compared     = 0;
  int mismatched   = 0;
  int doneCount    = 0;
  int expectedDone = 0;
  bit toggleReady  = 1'b0;
  bit corruptWay0  = 1'b0;

  logic [DW-1:0] arr0 [512][8];
  logic [DW-1:0] arr1 [512][8];

  typedef struct {
    logic [DW-1:0] data;
    logic [2:0]    beat;
    logic [PW-1:0] addr;
  } exp_beat_t;
  exp_beat_t expQ[$];

  dcache_writeback_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PADDR_WIDTH(PW)) dut (
    .clock(clock), .reset_n(reset_n),
    .wb_req_valid(wb_req_valid), .wb_req_ready(wb_req_ready),
    .wb_req_set(wb_req_set), .wb_req_way(wb_req_way), .wb_req_paddr(wb_req_paddr),
    .ce_way0(ce_way0), .ce_way1(ce_way1),
    .readwayaddr_way0(readwayaddr_way0), .readwayaddr_way1(readwayaddr_way1),
    .dout_way0(dout_way0), .dout_way1(dout_way1),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_beat(mem_wr_beat), .mem_wr_last(mem_wr_last),
    .mem_wr_ack(mem_wr_ack), .wb_done(wb_done), .wb_busy(wb_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Data array model: registered read, one cycle after the bank enable.
  always @(posedge clock) begin
    for (int b = 0; b < 8; b++) begin
      if (ce_way0[b]) dout_way0[b] <= arr0[readwayaddr_way0][b];
      else if (corruptWay0) dout_way0[b] <= {$urandom, $urandom};
      if (ce_way1[b]) dout_way1[b] <= arr1[readwayaddr_way1][b];
    end
  end

  // Memory-side ready: either always high or alternating every cycle.
  always @(posedge clock) begin
    #1;
    if (toggleReady) mem_wr_ready = ~mem_wr_ready;
    else mem_wr_ready = 1'b1;
  end

  // Beat monitor: compares accepted beats against the queue and checks stall stability.
  logic [DW-1:0] heldData;
  logic [2:0]    heldBeat;
  bit            holdPending = 1'b0;
  always @(negedge clock) begin
    exp_beat_t e;
    if (!reset_n) begin
      holdPending = 1'b0;
    end else begin
      if (wb_done) doneCount++;
      if (mem_wr_valid) begin
        if (holdPending) begin
          checkOutput("stall data stable", mem_wr_data, heldData);
          checkOutput("stall beat stable", 64'(mem_wr_beat), 64'(heldBeat));
        end
        if (mem_wr_ready) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected beat", 64'(mem_wr_beat), 64'hFFFF);
          end else begin
            e = expQ.pop_front();
            checkOutput("beat data", mem_wr_data, e.data);
            checkOutput("beat index", 64'(mem_wr_beat), 64'(e.beat));
            checkOutput("beat addr", 64'(mem_wr_addr), 64'(e.addr));
            checkOutput("beat last", 64'(mem_wr_last), 64'(e.beat == 3'd7));
          end
          holdPending = 1'b0;
        end else begin
          holdPending = 1'b1;
          heldData    = mem_wr_data;
          heldBeat    = mem_wr_beat;
        end
      end else begin
        if (holdPending) checkOutput("valid held during stall", 64'(mem_wr_valid), 64'd1);
        holdPending = 1'b0;
      end
    end
  end

  task automatic issueRequest(input logic [8:0] set, input logic way, input logic [31:0] paddr,
                              input logic [63:0] dataBase, input logic [31:0] expAddr,
                              output bit accepted);
    accepted = 1'b0;
    for (int i = 0; i < 8; i++)
      expQ.push_back('{data: dataBase + 64'(i), beat: 3'(i), addr: expAddr});
    wb_req_set   = set;
    wb_req_way   = way;
    wb_req_paddr = paddr;
    wb_req_valid = 1'b1;
    for (int c = 0; c < 40 && !accepted; c++) begin
      if (wb_req_ready) accepted = 1'b1;
      @(posedge clock);
      #1;
    end
    checkOutput("request accepted", 64'(accepted), 64'd1);
    if (!accepted) begin
      wb_req_valid = 1'b0;
      expQ.delete();
    end
  endtask

  task automatic applyStimulus(input logic [8:0] set, input logic way, input logic [31:0] paddr,
                               input logic [63:0] dataBase, input logic [31:0] expAddr,
                               input bit ackEarly, input bit holdNext, input logic [8:0] nSet,
                               input logic nWay, input logic [31:0] nPaddr);
    bit accepted;
    bit sawLast = 1'b0;
    issueRequest(set, way, paddr, dataBase, expAddr, accepted);
    if (!accepted) return;
    if (holdNext) begin
      wb_req_set   = nSet;
      wb_req_way   = nWay;
      wb_req_paddr = nPaddr;
    end else begin
      wb_req_valid = 1'b0;
    end
    @(negedge clock);
    checkOutput("read ce_way0", 64'(ce_way0), way ? 64'h00 : 64'hFF);
    checkOutput("read ce_way1", 64'(ce_way1), way ? 64'hFF : 64'h00);
    checkOutput("read addr way0", 64'(readwayaddr_way0), way ? 64'd0 : 64'(set));
    checkOutput("read addr way1", 64'(readwayaddr_way1), way ? 64'(set) : 64'd0);
    @(negedge clock);
    checkOutput("capture ce", 64'({ce_way0, ce_way1}), 64'd0);
    checkOutput("capture valid", 64'(mem_wr_valid), 64'd0);
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      mem_wr_ack = 1'b0;
      if (c == 0) checkOutput("first valid", 64'(mem_wr_valid), 64'd1);
      checkOutput("busy in burst", 64'(wb_busy), 64'd1);
      checkOutput("ready in burst", 64'(wb_req_ready), 64'd0);
      if (ackEarly && mem_wr_valid && (mem_wr_beat == 3'd2 || mem_wr_last)) mem_wr_ack = 1'b1;
      if (mem_wr_valid && mem_wr_ready && mem_wr_last) begin
        sawLast = 1'b1;
        break;
      end
    end
    checkOutput("last beat seen", 64'(sawLast), 64'd1);
    @(negedge clock);
    mem_wr_ack = 1'b0;
    checkOutput("valid after last", 64'(mem_wr_valid), 64'd0);
    repeat (4) begin
      @(negedge clock);
      checkOutput("no early done", 64'(wb_done), 64'd0);
      checkOutput("busy waiting ack", 64'(wb_busy), 64'd1);
    end
    @(posedge clock);
    #1 mem_wr_ack = 1'b1;
    @(negedge clock);
    checkOutput("done not with ack", 64'(wb_done), 64'd0);
    @(posedge clock);
    #1 mem_wr_ack = 1'b0;
    expectedDone++;
    @(negedge clock);
    checkOutput("done after ack", 64'(wb_done), 64'd1);
    checkOutput("ready after ack", 64'(wb_req_ready), 64'd1);
    checkOutput("idle after ack", 64'(wb_busy), 64'd0);
    #1;
    checkOutput("done count", 64'(doneCount), 64'(expectedDone));
    if (!holdNext) begin
      @(negedge clock);
      checkOutput("done is a pulse", 64'(wb_done), 64'd0);
      @(posedge clock);
      #1;
    end
  endtask

  task automatic applyResetMidBurst(input logic [8:0] set, input logic way, input logic [31:0] paddr,
                                    input logic [63:0] dataBase, input logic [31:0] expAddr);
    bit accepted;
    bit found = 1'b0;
    issueRequest(set, way, paddr, dataBase, expAddr, accepted);
    wb_req_valid = 1'b0;
    if (!accepted) return;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clock);
      if (mem_wr_valid && mem_wr_beat == 3'd3) found = 1'b1;
    end
    checkOutput("reached beat 3", 64'(found), 64'd1);
    reset_n = 1'b0;
    #1;
    expQ.delete();
    checkOutput("reset valid", 64'(mem_wr_valid), 64'd0);
    checkOutput("reset ready", 64'(wb_req_ready), 64'd1);
    checkOutput("reset busy", 64'(wb_busy), 64'd0);
    checkOutput("reset beat", 64'(mem_wr_beat), 64'd0);
    checkOutput("reset data", mem_wr_data, 64'd0);
    checkOutput("reset addr", 64'(mem_wr_addr), 64'd0);
    checkOutput("reset last", 64'(mem_wr_last), 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clock);
      checkOutput("no done after reset", 64'(wb_done), 64'd0);
    end
    #1;
    checkOutput("done count after reset", 64'(doneCount), 64'(expectedDone));
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int s = 0; s < 512; s++) begin
      for (int b = 0; b < 8; b++) begin
        arr0[s][b] = 64'(32'h5A00_0000 | (s << 8) | b);
        arr1[s][b] = 64'(32'h6B00_0000 | (s << 8) | b);
      end
    end
    for (int b = 0; b < 8; b++) begin
      arr1[9'h1A5][b] = 64'hA0 + 64'(b);
      arr0[9'h000][b] = 64'hB0 + 64'(b);
      arr0[9'h0FF][b] = 64'hC0 + 64'(b);
    end
    reset_n      = 1'b0;
    wb_req_valid = 1'b0;
    wb_req_set   = '0;
    wb_req_way   = 1'b0;
    wb_req_paddr = '0;
    mem_wr_ack   = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("init ready", 64'(wb_req_ready), 64'd1);
    checkOutput("init busy", 64'(wb_busy), 64'd0);
    checkOutput("init valid", 64'(mem_wr_valid), 64'd0);
    checkOutput("init done", 64'(wb_done), 64'd0);
    checkOutput("init ce", 64'({ce_way0, ce_way1}), 64'd0);
    checkOutput("init read addr", 64'({readwayaddr_way0, readwayaddr_way1}), 64'd0);
    checkOutput("init mem addr", 64'(mem_wr_addr), 64'd0);
    checkOutput("init data", mem_wr_data, 64'd0);
    checkOutput("init beat/last", 64'({mem_wr_beat, mem_wr_last}), 64'd0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    $display("[TB] basic burst way1 set 0x1A5");
    applyStimulus(9'h1A5, 1'b1, 32'h8000_1234, 64'hA0, 32'h8000_1200, 1'b0, 1'b0, 9'h0, 1'b0, 32'h0);

    $display("[TB] toggling ready with way0 data corrupted");
    toggleReady = 1'b1;
    corruptWay0 = 1'b1;
    applyStimulus(9'h1A5, 1'b1, 32'h8000_1234, 64'hA0, 32'h8000_1200, 1'b0, 1'b0, 9'h0, 1'b0, 32'h0);
    toggleReady = 1'b0;
    corruptWay0 = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    $display("[TB] stray acks during burst");
    applyStimulus(9'h1A5, 1'b1, 32'h8000_1234, 64'hA0, 32'h8000_1200, 1'b1, 1'b0, 9'h0, 1'b0, 32'h0);

    $display("[TB] request held while busy");
    applyStimulus(9'h1A5, 1'b1, 32'h8000_1234, 64'hA0, 32'h8000_1200, 1'b0, 1'b1,
                  9'h000, 1'b0, 32'h4000_007F);
    applyStimulus(9'h000, 1'b0, 32'h4000_007F, 64'hB0, 32'h4000_0040, 1'b0, 1'b0, 9'h0, 1'b0, 32'h0);

    $display("[TB] reset during beat 3");
    applyResetMidBurst(9'h0FF, 1'b0, 32'h1234_567F, 64'hC0, 32'h1234_5640);

    $display("[TB] request after reset");
    applyStimulus(9'h0FF, 1'b0, 32'h1234_567F, 64'hC0, 32'h1234_5640, 1'b0, 1'b0, 9'h0, 1'b0, 32'h0);

    repeat (2) @(negedge clock);
    checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
    checkOutput("total done pulses", 64'(doneCount), 64'd6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
